// File: rtl/ring_nic_if.sv
// rtl/ring_nic_if.sv - processor register bus and router PE-port handshake bundle for ring_nic
interface ring_nic_if #(
    parameter int DATA_W = 64
);
    logic [1:0]        addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              nicEn;
    logic              nicWrEn;
    logic              net_so;
    logic              net_ro;
    logic [DATA_W-1:0] net_do;
    logic              net_polarity;
    logic              net_si;
    logic              net_ri;
    logic [DATA_W-1:0] net_di;

    modport master (
        output addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
        input  d_out, net_so, net_do, net_ri
    );

    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
        output d_out, net_so, net_do, net_ri
    );
endinterface

// File: rtl/ring_nic.sv
// rtl/ring_nic.sv - one-deep in/out packet buffers between a PE and a gold-ring router (option: RING_NIC_POLARITY_EN)
module ring_nic #(
    parameter int DATA_W = 64
) (
    input  logic     clk,
    input  logic     reset,
    ring_nic_if.slave bus
);
    localparam logic [1:0] ADDR_IN_BUF  = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    logic [DATA_W-1:0] out_buf_q, out_buf_d;
    logic [DATA_W-1:0] in_buf_q, in_buf_d;
    logic              out_full_q, out_full_d;
    logic              in_full_q, in_full_d;
    logic              rd_en, wr_en, pol_ok, send;

    assign rd_en = bus.nicEn & ~bus.nicWrEn;
    assign wr_en = bus.nicEn & bus.nicWrEn;

`ifdef RING_NIC_POLARITY_EN
    // vc bit selects the ring phase in which this packet may enter
    assign pol_ok = (out_buf_q[DATA_W-1] == bus.net_polarity);
`else
    logic unused_polarity;
    assign unused_polarity = bus.net_polarity;
    assign pol_ok = 1'b1;
`endif

    assign send       = out_full_q & bus.net_ro & pol_ok;
    assign bus.net_so = send;
    assign bus.net_do = out_buf_q;
    assign bus.net_ri = ~in_full_q;

    always_comb begin
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;
        in_buf_d   = in_buf_q;
        in_full_d  = in_full_q;
        // send and accepted write are exclusive: one needs full, the other empty
        if (send) begin
            out_full_d = 1'b0;
        end else if (wr_en && bus.addr == ADDR_OUT_BUF && !out_full_q) begin
            out_buf_d  = bus.d_in;
            out_full_d = 1'b1;
        end
        if (rd_en && bus.addr == ADDR_IN_BUF) begin
            in_full_d = 1'b0;
        end
        // arrival only possible while empty, so it never races a consuming read
        if (bus.net_si && !in_full_q) begin
            in_buf_d  = bus.net_di;
            in_full_d = 1'b1;
        end
    end

    always_comb begin
        bus.d_out = '0;
        if (rd_en) begin
            case (bus.addr)
                ADDR_IN_BUF:   bus.d_out = in_buf_q;
                ADDR_IN_STAT:  bus.d_out = {{(DATA_W-1){1'b0}}, in_full_q};
                ADDR_OUT_BUF:  bus.d_out = '0;
                ADDR_OUT_STAT: bus.d_out = {{(DATA_W-1){1'b0}}, out_full_q};
                default:       bus.d_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_buf_q  <= '0;
            out_full_q <= 1'b0;
            in_buf_q   <= '0;
            in_full_q  <= 1'b0;
        end else begin
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
        end
    end
endmodule

// File: tb/tb_ring_nic.sv
// tb/tb_ring_nic.sv - directed plus randomized bench for ring_nic against a packet-queue reference model
module tb_ring_nic;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ring_nic_if #(.DATA_W(64)) bus ();
    ring_nic #(.DATA_W(64)) dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic [63:0] out_q[$];
    logic [63:0] in_q[$];
    logic [63:0] last_out = '0;
    logic [63:0] last_in = '0;

    logic [63:0] obs_d, obs_do;
    logic        obs_so, obs_ri;
    int          sends = 0;

    localparam logic [63:0] PKT_A = 64'h0000_0001_0001_0003;
    localparam logic [63:0] PKT_B = 64'h0000_0002_0005_0007;
    localparam logic [63:0] PKT_R = 64'h4000_0003_0002_0001;
    localparam logic [63:0] PKT_S = 64'h0000_0009_0008_0007;

    task automatic chk(string tag, logic [63:0] observed, logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit model_pol_ok();
`ifdef RING_NIC_POLARITY_EN
        return last_out[63] == bus.net_polarity;
`else
        return 1'b1;
`endif
    endfunction

    // one clock: check combinational outputs mid-cycle, then advance the model at the edge
    task automatic cycle();
        logic [63:0] exp_d;
        bit          exp_so, had_out, had_in;
        #1;
        exp_so = (out_q.size() > 0) && bus.net_ro && model_pol_ok();
        exp_d = '0;
        if (bus.nicEn && !bus.nicWrEn) begin
            case (bus.addr)
                2'd0: exp_d = last_in;
                2'd1: exp_d = 64'(in_q.size());
                2'd2: exp_d = '0;
                default: exp_d = 64'(out_q.size());
            endcase
        end
        obs_d = bus.d_out; obs_so = bus.net_so; obs_ri = bus.net_ri; obs_do = bus.net_do;
        if (check_en) begin
            chk("d_out", obs_d, exp_d);
            chk("net_so", 64'(obs_so), 64'(exp_so));
            chk("net_ri", 64'(obs_ri), 64'(in_q.size() == 0));
            chk("net_do", obs_do, last_out);
        end
        @(posedge clk);
        if (!reset) begin
            out_q.delete(); in_q.delete();
            last_out = '0; last_in = '0;
        end else begin
            had_out = out_q.size() > 0;
            had_in  = in_q.size() > 0;
            if (exp_so) begin
                void'(out_q.pop_front());
                sends++;
            end
            if (bus.nicEn && bus.nicWrEn && bus.addr == 2'd2 && !had_out) begin
                out_q.push_back(bus.d_in);
                last_out = bus.d_in;
            end
            if (bus.nicEn && !bus.nicWrEn && bus.addr == 2'd0 && had_in)
                void'(in_q.pop_front());
            if (bus.net_si && !had_in) begin
                in_q.push_back(bus.net_di);
                last_in = bus.net_di;
            end
        end
        if (!reset) check_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.nicEn = 1'b0; bus.nicWrEn = 1'b0; bus.addr = 2'd0; bus.d_in = '0;
        bus.net_si = 1'b0; bus.net_di = '0;
        cycle();
    endtask

    task automatic rd(logic [1:0] a);
        bus.nicEn = 1'b1; bus.nicWrEn = 1'b0; bus.addr = a; bus.net_si = 1'b0;
        cycle();
        bus.nicEn = 1'b0;
    endtask

    task automatic wr(logic [1:0] a, logic [63:0] v);
        bus.nicEn = 1'b1; bus.nicWrEn = 1'b1; bus.addr = a; bus.d_in = v; bus.net_si = 1'b0;
        cycle();
        bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
    endtask

    task automatic arrive(logic [63:0] v);
        bus.nicEn = 1'b0; bus.net_si = 1'b1; bus.net_di = v;
        cycle();
        bus.net_si = 1'b0;
    endtask

    initial begin
        int s0;
        bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) idle();
        reset = 1'b1;
        idle();
        chk("rst_d_out", obs_d, 64'd0);
        chk("rst_net_so", 64'(obs_so), 64'd0);
        chk("rst_net_ri", 64'(obs_ri), 64'd1);
        rd(2'd1); chk("rst_in_stat", obs_d, 64'd0);
        rd(2'd3); chk("rst_out_stat", obs_d, 64'd0);

        bus.net_ro = 1'b1; bus.net_polarity = 1'b0;
        wr(2'd2, PKT_A);
        idle();
        chk("inject_so", 64'(obs_so), 64'd1);
        chk("inject_do", obs_do, PKT_A);
        idle();
        chk("inject_once", 64'(obs_so), 64'd0);
        rd(2'd3); chk("out_stat_after", obs_d, 64'd0);

        bus.net_polarity = 1'b1;
        wr(2'd2, PKT_A);
        s0 = sends;
        idle();
        wr(2'd2, PKT_B);
        repeat (3) idle();
        bus.net_polarity = 1'b0;
        idle();
`ifdef RING_NIC_POLARITY_EN
        chk("pol_wait_sends", 64'(sends - s0), 64'd1);
        chk("pol_fire_do", obs_do, PKT_A);
        chk("pol_fire_so", 64'(obs_so), 64'd1);
`else
        chk("nopol_sends", 64'(sends - s0), 64'd2);
        chk("nopol_last_do", obs_do, PKT_B);
`endif
        idle();

        arrive(PKT_R);
        idle(); chk("rx_ri_low", 64'(obs_ri), 64'd0);
        rd(2'd1); chk("rx_stat_full", obs_d, 64'd1);
        arrive(PKT_S);
        rd(2'd0); chk("rx_data", obs_d, PKT_R);
        idle(); chk("rx_ri_high", 64'(obs_ri), 64'd1);
        rd(2'd1); chk("rx_stat_empty", obs_d, 64'd0);
        rd(2'd0); chk("rx_stale", obs_d, PKT_R);

        bus.net_ro = 1'b0;
        wr(2'd2, PKT_B);
        arrive(PKT_S);
        rd(2'd3); chk("both_full_out", obs_d, 64'd1);
        reset = 1'b0;
        idle();
        reset = 1'b1;
        bus.net_ro = 1'b1;
        idle();
        chk("rst2_so", 64'(obs_so), 64'd0);
        chk("rst2_ri", 64'(obs_ri), 64'd1);
        rd(2'd3); chk("rst2_out_stat", obs_d, 64'd0);
        rd(2'd1); chk("rst2_in_stat", obs_d, 64'd0);

        for (int i = 0; i < 600; i++) begin
            reset            = ($urandom_range(0, 49) != 0);
            bus.nicEn        = $urandom_range(0, 1);
            bus.nicWrEn      = $urandom_range(0, 1);
            bus.addr         = 2'($urandom_range(0, 3));
            bus.d_in         = {$urandom, $urandom};
            bus.net_ro       = ($urandom_range(0, 3) != 0);
            bus.net_polarity = $urandom_range(0, 1);
            bus.net_si       = $urandom_range(0, 1);
            bus.net_di       = {$urandom, $urandom};
            cycle();
        end
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
